// File: rtl/core_seq_pkg.sv
// core_seq_pkg: sequencer state encodings and the nop instruction constant
package core_seq_pkg;
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        HALT       = 3'd6,
        ERR        = 3'd7
    } seq_state_t;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/core_seq_timer.sv
// seq_timer: response wait counter (clk, rst, clr restarts, en counts, expired at MAX_WAIT-1)
module seq_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(MAX_WAIT - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/core_seq.sv
// core_seq: fetch/exec/mem/wb sequencer; imem/dmem valid-ready requests, inst latch, pc/reg write strobes, instret, sticky halted/err
module core_seq
    import core_seq_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     inst,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_reg_w,
    input  logic            dec_halt,
    output logic            dmem_req_valid,
    output logic            dmem_we,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    output logic            pc_w_en,
    output logic            reg_w_en,
    output logic            halted,
    output logic            err,
    output logic [63:0]     instret,
    output logic [2:0]      state
);
    seq_state_t st;
    logic       is_store;
    logic       reg_w;
    logic       expired;
    assign imem_req_valid = !rst && st == FETCH_REQ;
    assign imem_addr      = pc;
    assign dmem_req_valid = !rst && st == MEM_REQ;
    assign dmem_we        = is_store;
    assign pc_w_en        = !rst && st == WB;
    assign reg_w_en       = pc_w_en && reg_w && !is_store;
    assign halted         = st == HALT;
    assign err            = st == ERR;
    assign state          = st;
    seq_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    ((imem_req_valid && imem_req_ready) || (dmem_req_valid && dmem_req_ready)),
        .en     ((st == FETCH_WAIT && !imem_rsp_valid) || (st == MEM_WAIT && !dmem_rsp_valid)),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= FETCH_REQ;
            inst     <= INST_NOP;
            instret  <= '0;
            is_store <= 1'b0;
            reg_w    <= 1'b0;
        end else begin
            case (st)
                FETCH_REQ:  st <= imem_req_ready ? FETCH_WAIT : FETCH_REQ;
                FETCH_WAIT: begin
                    if (imem_rsp_valid) inst <= imem_rsp_data;
                    st <= imem_rsp_valid ? EXEC : expired ? ERR : FETCH_WAIT;
                end
                EXEC: begin
                    is_store <= dec_store;
                    reg_w    <= dec_reg_w;
                    st <= dec_halt ? HALT : (dec_load || dec_store) ? MEM_REQ : WB;
                end
                MEM_REQ:  st <= dmem_req_ready ? MEM_WAIT : MEM_REQ;
                MEM_WAIT: st <= dmem_rsp_valid ? WB : expired ? ERR : MEM_WAIT;
                WB: begin
                    instret <= instret + 64'd1;
                    st      <= FETCH_REQ;
                end
                default: st <= st;
            endcase
        end
    end
endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle instruction sequencer for the RV64 core. It replaces the free-running single-cycle step with an explicit fetch → execute → memory → writeback FSM. It issues valid/ready requests to instruction and data memory, and latches the fetched instruction for the decoder. It gates PC update and register-file write so that state changes exactly once per retired instruction. It sits beside the control decoder in the top level: the decoder consumes `inst`, and the PC and register file consume `pc_w_en` and `reg_w_en`.

## Interface
Reset is synchronous and active-high; one clock.

Parameters:
- `XLEN`, 64, datapath/address width.
- `MAX_WAIT`, 16, maximum cycles a memory response may take after request acceptance; must be ≥ 2.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous reset, active-high, sampled on posedge.
- `pc` in XLEN: current PC from the PC register.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: fetch request accepted.
- `imem_addr` out XLEN: fetch address; equals `pc` while `imem_req_valid`=1.
- `imem_rsp_valid` in 1: fetch data valid.
- `imem_rsp_data` in 32: fetched instruction.
- `inst` out 32: latched instruction register.
- `dec_load` in 1: decoder flags a load (valid in EXEC).
- `dec_store` in 1: decoder flags a store.
- `dec_reg_w` in 1: decoder register-write enable.
- `dec_halt` in 1: decoder flags ebreak.
- `dmem_req_valid` out 1: data request.
- `dmem_we` out 1: data request is a write; equals latched `dec_store`.
- `dmem_req_ready` in 1: data request accepted.
- `dmem_rsp_valid` in 1: data response (load data or store ack).
- `pc_w_en` out 1: PC advance strobe.
- `reg_w_en` out 1: gated register-file write.
- `halted` out 1: sticky, ebreak reached.
- `err` out 1: sticky, memory response timeout.
- `instret` out 64: retired-instruction count.
- `state` out 3: FSM state, for debug.

## Operation
- States and encodings: FETCH_REQ=0, FETCH_WAIT=1, EXEC=2, MEM_REQ=3, MEM_WAIT=4, WB=5, HALT=6, ERR=7.
- **FETCH_REQ**
  - `imem_req_valid`=1.
  - `imem_req_ready`=1 → FETCH_WAIT, wait counter cleared.
  - `imem_rsp_valid` is ignored in this state.
- **FETCH_WAIT**
  - `imem_rsp_valid`=1 → `inst` ← `imem_rsp_data`, go to EXEC.
  - Otherwise the counter increments; counter = MAX_WAIT−1 with no response → ERR.
- **EXEC** (exactly 1 cycle; decoder flags are sampled here into mem_op/is_store/reg_w flops)
  - `dec_halt` → HALT. Halt has priority over load/store.
  - `dec_load|dec_store` → MEM_REQ.
  - Otherwise → WB.
- **MEM_REQ**
  - `dmem_req_valid`=1, `dmem_we`=latched store.
  - `dmem_req_ready` → MEM_WAIT, counter cleared.
- **MEM_WAIT**
  - `dmem_rsp_valid` → WB.
  - Same timeout rule as FETCH_WAIT → ERR.
- **WB** (1 cycle)
  - `pc_w_en`=1.
  - `reg_w_en` = latched `dec_reg_w` & ~latched store.
  - `instret` += 1, wrapping modulo 2^64.
  - Next state → FETCH_REQ.
- **HALT**: `halted`=1, sticky until `rst`. No requests issued; `pc_w_en`=`reg_w_en`=0. HALT does not retire the ebreak (`instret` unchanged).
- **ERR**: `err`=1, sticky until `rst`. Outputs otherwise as in HALT.
- Request/strobe outputs are a Moore decode of `state`, forced to 0 while `rst`=1.
- A request, once raised, stays asserted until accepted; the address/we are stable meanwhile.
- Reset mid-operation:
  - Abandons any outstanding request.
  - A late `*_rsp_valid` arriving in FETCH_REQ/MEM_REQ after reset is ignored.

## Timing
- Reset values: state=FETCH_REQ, `inst`=32'h0000_0013 (nop), `instret`=0, `halted`=`err`=0, counter=0. All request and strobe outputs are 0 during the reset cycle.
- First `imem_req_valid` is asserted in the first cycle with `rst`=0.
- Zero-wait memory (ready=1, response the next cycle):
  - ALU instruction: 4 cycles, FETCH_REQ→FETCH_WAIT→EXEC→WB.
  - Load/store: 6 cycles.
- Each request stall or response stall cycle adds exactly 1 cycle.
- `pc_w_en` and `reg_w_en` are high for exactly one cycle per instruction, in the same cycle. The PC and RF commit on the following posedge.
- `inst` changes only on the FETCH_WAIT→EXEC edge and holds through WB.

## Structure
- Shared package `core_seq_pkg`:
  - `seq_state_t` enum (3-bit encodings above).
  - `INST_NOP` constant.
- Sub-module `seq_timer`:
  - MAX_WAIT-parameterized counter with `clr`, `en`, and a `expired` output (counter = MAX_WAIT−1).
  - Shared by FETCH_WAIT and MEM_WAIT.
- The FSM, latched decode flags, `inst` register and `instret` counter live in `core_seq`.

## Test plan
- Zero-wait imem returning 32'h00500093 (addi) three times → exactly 3 `pc_w_en` pulses at cycles 4, 8, 12 after reset release; `reg_w_en` coincides; `instret`=3.
- Load with `imem_req_ready` low 2 cycles and dmem response after 3 cycles → `dmem_we`=0, WB occurs at cycle 6+2+2=10, one `reg_w_en`.
- Store (`dec_store`=1, `dec_reg_w`=1) → `dmem_we`=1 held through stall, WB has `pc_w_en`=1 and `reg_w_en`=0.
- `dec_halt`=1 in EXEC → HALT, `halted`=1, no further `imem_req_valid`, `instret` unchanged; `rst` → state=0, `halted`=0.
- MAX_WAIT=4, imem never responds → ERR entered 4 cycles after acceptance, `err`=1 sticky, no strobes.
- `rst` asserted in MEM_WAIT with `dmem_rsp_valid` arriving on the next cycle → state=FETCH_REQ, `inst`=nop, no `reg_w_en`, stray response ignored.
